// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Two-requester arbiter and sequencer in front of a shared byte-addressed data
// memory (combinational read, posedge write, MemRead/MemWrite strobes).
// Port 0 is the CPU load/store stage, port 1 is a DMA/debug loader. One word
// access is serviced at a time; conflicts are resolved round-robin.
// Misaligned or out-of-range addresses are answered with an error response
// and never reach the memory.
//
// Optional feature (compile-time macro):
//   DMEM_ARB_FIXED_PRIO_EN  defined   -> port 0 always wins a conflict
//                                        (port 1 can starve).
//                           undefined -> round-robin (default build).
//
// Handshake (both ports): the requester raises reqN_i together with weN_i,
// addrN_i and wdataN_i and holds all of them stable until it sees ackN_o.
// ackN_o is a single-cycle pulse; errN_o and rdataN_o are valid while ackN_o
// is high. The requester must drop reqN_i in the cycle ackN_o is high; a
// request still high when the arbiter is back in IDLE is a new request.
// Requests are only sampled in IDLE.
//
// Ports:
//   clk_i                 clock
//   rst_n                 asynchronous active-low reset
//   req0_i / req1_i       request, held until ack
//   we0_i / we1_i         1 = write, 0 = read
//   addr0_i / addr1_i     byte address (must be word aligned, <= MEM_BYTES-4)
//   wdata0_i / wdata1_i   write data
//   ack0_o / ack1_o       one-cycle completion pulse
//   err0_o / err1_o       error flag, valid with ack
//   rdata0_o / rdata1_o   registered read data
//   mem_addr_o            memory address
//   mem_data_o            memory write data
//   mem_read_o            memory MemRead strobe
//   mem_write_o           memory MemWrite strobe
//   mem_data_i            memory read data (combinational)
//   dbg_state_o           current FSM state (IDLE=0, ACCESS=1, RESP=2)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 128
) (
  input  logic              clk_i,
  input  logic              rst_n,
  // port 0 (CPU)
  input  logic              req0_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  output logic              ack0_o,
  output logic              err0_o,
  output logic [DATA_W-1:0] rdata0_o,
  // port 1 (DMA / debug loader)
  input  logic              req1_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              ack1_o,
  output logic              err1_o,
  output logic [DATA_W-1:0] rdata1_o,
  // memory side
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  input  logic [DATA_W-1:0] mem_data_i,
  // debug
  output logic [1:0]        dbg_state_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // Highest legal word address. Compared unsigned over the full address width
  // so that addresses close to 2^ADDR_W cannot wrap into the legal window.
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);

  logic [1:0] state;
  logic       gnt_port;   // 0 = port 0, 1 = port 1
  logic       gnt_we;

`ifndef DMEM_ARB_FIXED_PRIO_EN
  logic       last_grant; // port that won the most recent grant
`endif

  // ---------------------------------------------------------------------------
  // Arbitration and request selection (only meaningful in IDLE)
  // ---------------------------------------------------------------------------
  logic              any_req;
  logic              pick;      // winning port
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_legal;

  always_comb begin
    any_req = req0_i | req1_i;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    // Port 0 wins whenever it asks.
    pick = ~req0_i;
`else
    // On a conflict the port that did not win last time goes next; a single
    // requester is simply granted.
    if (req0_i && req1_i) begin
      pick = ~last_grant;
    end else begin
      pick = ~req0_i;
    end
`endif
    sel_we    = pick ? we1_i    : we0_i;
    sel_addr  = pick ? addr1_i  : addr0_i;
    sel_wdata = pick ? wdata1_i : wdata0_i;
    sel_legal = (sel_addr[1:0] == 2'b00) && (sel_addr <= LAST_WORD);
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  //   IDLE   : grant; legal -> raise one strobe, go ACCESS
  //                   illegal -> answer with error immediately, go RESP
  //   ACCESS : one cycle with one strobe high; read data captured at its end
  //   RESP   : ack pulse visible for this single cycle
  // Ack/err are registered on the edge that enters RESP so that they are high
  // exactly for the RESP cycle and cleared on the following edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      gnt_port    <= 1'b0;
      gnt_we      <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_grant  <= 1'b1;  // port 0 wins the first conflict after reset
`endif
      ack0_o      <= 1'b0;
      err0_o      <= 1'b0;
      rdata0_o    <= '0;
      ack1_o      <= 1'b0;
      err1_o      <= 1'b0;
      rdata1_o    <= '0;
      mem_addr_o  <= '0;
      mem_data_o  <= '0;
      mem_read_o  <= 1'b0;
      mem_write_o <= 1'b0;
    end else begin
      // Response flags are single-cycle pulses by default.
      ack0_o <= 1'b0;
      err0_o <= 1'b0;
      ack1_o <= 1'b0;
      err1_o <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (any_req) begin
            gnt_port <= pick;
            gnt_we   <= sel_we;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_grant <= pick;
`endif
            if (sel_legal) begin
              mem_addr_o  <= sel_addr;
              mem_data_o  <= sel_wdata;
              mem_read_o  <= ~sel_we;
              mem_write_o <= sel_we;
              state       <= ST_ACCESS;
            end else begin
              // Memory is left untouched; the response is issued directly.
              // An errored read returns zero, an errored write keeps rdata.
              if (pick) begin
                ack1_o <= 1'b1;
                err1_o <= 1'b1;
                if (!sel_we) begin
                  rdata1_o <= '0;
                end
              end else begin
                ack0_o <= 1'b1;
                err0_o <= 1'b1;
                if (!sel_we) begin
                  rdata0_o <= '0;
                end
              end
              state <= ST_RESP;
            end
          end
        end

        ST_ACCESS: begin
          // The memory commits a write (or presents read data) at this edge.
          mem_read_o  <= 1'b0;
          mem_write_o <= 1'b0;
          if (gnt_port) begin
            ack1_o <= 1'b1;
            if (!gnt_we) begin
              rdata1_o <= mem_data_i;
            end
          end else begin
            ack0_o <= 1'b1;
            if (!gnt_we) begin
              rdata0_o <= mem_data_i;
            end
          end
          state <= ST_RESP;
        end

        ST_RESP: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dbg_state_o = state;

endmodule
